// File: rtl/moving_avg_mc.sv
// Multi-channel time-multiplexed averager: per-channel boxcar (moving sum) or
// first-order exponential filter, selectable per sample, output = acc >>> LOG2_STAGES.
module moving_avg_mc #(
  parameter int BITS_X      = 12,
  parameter int LOG2_STAGES = 4,
  parameter int CHANNELS    = 2,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     mode,
  input  logic                     in_valid,
  input  logic [CH_W-1:0]          in_chan,
  input  logic signed [BITS_X-1:0] data_in,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_chan,
  output logic                     out_warm,
  output logic signed [BITS_X-1:0] data_out
);

  localparam int DEPTH  = 1 << LOG2_STAGES;
  localparam int ACC_W  = BITS_X + LOG2_STAGES;
  localparam int FILL_W = LOG2_STAGES + 1;
  localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);

  logic                     v1_q, m1_q;
  logic [CH_W-1:0]          ch1_q;
  logic signed [BITS_X-1:0] x1_q;
  logic                     v2_q, w2_q;
  logic [CH_W-1:0]          ch2_q;
  logic signed [BITS_X-1:0] y2_q;
  logic                     out_valid_q, out_warm_q;
  logic [CH_W-1:0]          out_chan_q;
  logic signed [BITS_X-1:0] data_out_q;

  logic signed [ACC_W-1:0]  acc_q  [CHANNELS];
  logic [LOG2_STAGES-1:0]   ptr_q  [CHANNELS];
  logic [FILL_W-1:0]        fill_q [CHANNELS];
  logic signed [BITS_X-1:0] hist_q [CHANNELS][DEPTH];

  logic signed [ACC_W-1:0]  acc_cur, x_ext, old_ext, acc_d, acc_sh;
  logic signed [BITS_X-1:0] old_raw, y_d;
  logic [LOG2_STAGES-1:0]   ptr_cur, ptr_d;
  logic [FILL_W-1:0]        fill_cur, fill_d;
  logic                     w_d;

  // State is read and written back in the same stage, so consecutive samples of
  // one channel always see the fully updated acc/ptr/fill/hist of the previous one.
  always_comb begin
    acc_cur  = acc_q[ch1_q];
    ptr_cur  = ptr_q[ch1_q];
    fill_cur = fill_q[ch1_q];
    old_raw  = hist_q[ch1_q][ptr_cur];
    x_ext    = {{LOG2_STAGES{x1_q[BITS_X-1]}}, x1_q};
    old_ext  = '0;
    if (fill_cur == FULL) begin
      old_ext = {{LOG2_STAGES{old_raw[BITS_X-1]}}, old_raw};
    end
    if (m1_q) begin
      acc_d = acc_cur + x_ext - (acc_cur >>> LOG2_STAGES);
    end else begin
      acc_d = acc_cur + x_ext - old_ext;
    end
    acc_sh = acc_d >>> LOG2_STAGES;
    y_d    = acc_sh[BITS_X-1:0];
    ptr_d  = ptr_cur + LOG2_STAGES'(1);
    fill_d = (fill_cur == FULL) ? fill_cur : fill_cur + FILL_W'(1);
    w_d    = (fill_d == FULL);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1_q        <= 1'b0;
      m1_q        <= 1'b0;
      ch1_q       <= '0;
      x1_q        <= '0;
      v2_q        <= 1'b0;
      w2_q        <= 1'b0;
      ch2_q       <= '0;
      y2_q        <= '0;
      out_valid_q <= 1'b0;
      out_warm_q  <= 1'b0;
      out_chan_q  <= '0;
      data_out_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c]  <= '0;
        ptr_q[c]  <= '0;
        fill_q[c] <= '0;
      end
    end else if (clear) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c]  <= '0;
        ptr_q[c]  <= '0;
        fill_q[c] <= '0;
      end
    end else if (enable) begin
      v1_q  <= in_valid;
      m1_q  <= mode;
      ch1_q <= in_chan;
      x1_q  <= data_in;
      v2_q  <= v1_q;
      ch2_q <= ch1_q;
      y2_q  <= y_d;
      w2_q  <= w_d;
      if (v1_q) begin
        acc_q[ch1_q]  <= acc_d;
        ptr_q[ch1_q]  <= ptr_d;
        fill_q[ch1_q] <= fill_d;
      end
      out_valid_q <= v2_q;
      if (v2_q) begin
        out_chan_q <= ch2_q;
        data_out_q <= y2_q;
        out_warm_q <= w2_q;
      end
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  // History contents are deliberately not reset; fill gates their use.
  always_ff @(posedge clock) begin
    if (enable && !clear && v1_q) begin
      hist_q[ch1_q][ptr_cur] <= x1_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_warm  = out_warm_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_moving_avg_mc.sv
// Directed bench for moving_avg_mc (BITS_X=12, LOG2_STAGES=2, CHANNELS=2);
// each task drives a vector table and compares against hand-computed results.
module tb_moving_avg_mc;

  logic              clock = 1'b0;
  logic              reset, enable, clear, mode, in_valid;
  logic [0:0]        in_chan;
  logic signed [11:0] data_in;
  logic              out_valid, out_warm;
  logic [0:0]        out_chan;
  logic signed [11:0] data_out;

  always #5 clock = ~clock;

  moving_avg_mc #(.BITS_X(12), .LOG2_STAGES(2), .CHANNELS(2)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .mode(mode),
    .in_valid(in_valid), .in_chan(in_chan), .data_in(data_in),
    .out_valid(out_valid), .out_chan(out_chan), .out_warm(out_warm), .data_out(data_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus table (one entry per clock) and captured outputs after each edge
  logic               sv[32], sc[32], se[32], sclr[32];
  logic signed [11:0] sd[32];
  logic               ov[32], oc[32], ow[32];
  logic signed [11:0] od[32];

  task automatic clear_stim();
    for (int t = 0; t < 32; t++) begin
      sv[t] = 1'b0; sc[t] = 1'b0; sd[t] = '0; se[t] = 1'b1; sclr[t] = 1'b0;
    end
  endtask

  task automatic run_seq(input int n);
    for (int t = 0; t < n; t++) begin
      in_valid = sv[t]; in_chan = sc[t]; data_in = sd[t]; enable = se[t]; clear = sclr[t];
      @(posedge clock); #1;
      ov[t] = out_valid; oc[t] = out_chan; od[t] = data_out; ow[t] = out_warm;
    end
    in_valid = 1'b0; enable = 1'b1; clear = 1'b0;
  endtask

  task automatic do_clear();
    in_valid = 1'b0; enable = 1'b1; clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; clear = 1'b0; mode = 1'b0;
    in_valid = 1'b0; in_chan = '0; data_in = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_chan !== 1'b0 || out_warm !== 1'b0 || data_out !== 12'sd0) begin
      n_bad++;
      $display("FAIL reset_state: got v=%0b c=%0d w=%0b d=%0d, want all 0",
               out_valid, out_chan, out_warm, data_out);
    end
  endtask

  task automatic test_boxcar_step();
    int e;
    do_clear(); clear_stim(); mode = 1'b0;
    for (int k = 0; k < 8; k++) begin sv[k] = 1'b1; sd[k] = 12'sd400; end
    run_seq(11);
    for (int t = 0; t < 2; t++) begin
      n_cmp++;
      if (ov[t] !== 1'b0) begin
        n_bad++;
        $display("FAIL boxcar_latency[%0d]: got v=%0b, want v=0", t, ov[t]);
      end
    end
    for (int k = 0; k < 8; k++) begin
      e = (k < 3) ? 100 * (k + 1) : 400;
      n_cmp++;
      if (ov[k+2] !== 1'b1 || od[k+2] !== e || oc[k+2] !== 1'b0 || ow[k+2] !== (k >= 3)) begin
        n_bad++;
        $display("FAIL boxcar_step[%0d]: got v=%0b d=%0d c=%0d w=%0b, want v=1 d=%0d c=0 w=%0b",
                 k, ov[k+2], od[k+2], oc[k+2], ow[k+2], e, (k >= 3));
      end
    end
    n_cmp++;
    if (ov[10] !== 1'b0) begin
      n_bad++;
      $display("FAIL boxcar_tail: got v=%0b, want v=0", ov[10]);
    end
  endtask

  task automatic test_exp_step();
    int ee[8] = '{100, 175, 231, 273, 305, 329, 346, 360};
    do_clear(); clear_stim(); mode = 1'b1;
    for (int k = 0; k < 8; k++) begin sv[k] = 1'b1; sd[k] = 12'sd400; end
    run_seq(11);
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (ov[k+2] !== 1'b1 || od[k+2] !== ee[k] || ow[k+2] !== (k >= 3)) begin
        n_bad++;
        $display("FAIL exp_step[%0d]: got v=%0b d=%0d w=%0b, want v=1 d=%0d w=%0b",
                 k, ov[k+2], od[k+2], ow[k+2], ee[k], (k >= 3));
      end
    end
    mode = 1'b0;
  endtask

  task automatic test_boxcar_ramp();
    int xin[8] = '{10, 20, 30, 40, 50, 60, -70, -70};
    int ee[8]  = '{2, 7, 15, 25, 35, 45, 20, -8};
    do_clear(); clear_stim(); mode = 1'b0;
    for (int k = 0; k < 8; k++) begin sv[k] = 1'b1; sd[k] = 12'(xin[k]); end
    run_seq(10);
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (ov[k+2] !== 1'b1 || od[k+2] !== ee[k]) begin
        n_bad++;
        $display("FAIL boxcar_ramp[%0d]: got v=%0b d=%0d, want v=1 d=%0d",
                 k, ov[k+2], od[k+2], ee[k]);
      end
    end
  endtask

  task automatic test_interleave();
    int cnt[2];
    int e, n;
    logic ch;
    for (int pass = 0; pass < 2; pass++) begin
      do_clear(); clear_stim(); mode = 1'b0;
      n = (pass == 0) ? 8 : 9;
      for (int k = 0; k < n; k++) begin
        sv[k] = 1'b1;
        sc[k] = (pass == 0) ? k[0] : ((k % 3) == 2);
        sd[k] = sc[k] ? -12'sd400 : 12'sd400;
      end
      run_seq(n + 3);
      cnt[0] = 0; cnt[1] = 0;
      for (int k = 0; k < n; k++) begin
        ch = sc[k];
        cnt[ch]++;
        e = (ch ? -100 : 100) * ((cnt[ch] < 4) ? cnt[ch] : 4);
        n_cmp++;
        if (ov[k+2] !== 1'b1 || oc[k+2] !== ch || od[k+2] !== e || ow[k+2] !== (cnt[ch] >= 4)) begin
          n_bad++;
          $display("FAIL interleave%0d[%0d]: got v=%0b c=%0d d=%0d w=%0b, want v=1 c=%0d d=%0d w=%0b",
                   pass, k, ov[k+2], oc[k+2], od[k+2], ow[k+2], ch, e, (cnt[ch] >= 4));
        end
      end
    end
  endtask

  task automatic test_negative();
    int e;
    do_clear(); clear_stim(); mode = 1'b0;
    for (int k = 0; k < 6; k++) begin sv[k] = 1'b1; sd[k] = -12'sd1; end
    run_seq(8);
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (ov[k+2] !== 1'b1 || od[k+2] !== -1) begin
        n_bad++;
        $display("FAIL neg_floor[%0d]: got v=%0b d=%0d, want v=1 d=-1", k, ov[k+2], od[k+2]);
      end
    end
    do_clear(); clear_stim();
    for (int k = 0; k < 4; k++) begin sv[k] = 1'b1; sd[k] = -12'sd2048; end
    run_seq(6);
    for (int k = 0; k < 4; k++) begin
      e = -512 * (k + 1);
      n_cmp++;
      if (ov[k+2] !== 1'b1 || od[k+2] !== e || ow[k+2] !== (k == 3)) begin
        n_bad++;
        $display("FAIL full_scale[%0d]: got v=%0b d=%0d w=%0b, want v=1 d=%0d w=%0b",
                 k, ov[k+2], od[k+2], ow[k+2], e, (k == 3));
      end
    end
  endtask

  task automatic test_stall();
    int ev[14] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
    int ed[14] = '{0, 0, 100, 100, 100, 100, 100, 100, 200, 300, 400, 400, 400, 400};
    int ew[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    do_clear(); clear_stim(); mode = 1'b0;
    for (int t = 0; t < 11; t++) begin sv[t] = 1'b1; sd[t] = 12'sd400; end
    for (int t = 3; t < 8; t++) se[t] = 1'b0;
    run_seq(14);
    for (int t = 2; t < 14; t++) begin
      n_cmp++;
      if (ov[t] !== ev[t][0] || od[t] !== ed[t] || ow[t] !== ew[t][0]) begin
        n_bad++;
        $display("FAIL stall[%0d]: got v=%0b d=%0d w=%0b, want v=%0d d=%0d w=%0d",
                 t, ov[t], od[t], ow[t], ev[t], ed[t], ew[t]);
      end
    end
  endtask

  task automatic test_clear_inflight();
    int e;
    do_clear(); clear_stim(); mode = 1'b0;
    for (int t = 0; t < 7; t++) begin sv[t] = 1'b1; sd[t] = 12'sd400; end
    sclr[2] = 1'b1;
    run_seq(10);
    for (int t = 2; t < 5; t++) begin
      n_cmp++;
      if (ov[t] !== 1'b0) begin
        n_bad++;
        $display("FAIL clear_kill[%0d]: got v=%0b, want v=0", t, ov[t]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      e = 100 * (k + 1);
      n_cmp++;
      if (ov[k+5] !== 1'b1 || od[k+5] !== e || ow[k+5] !== (k == 3)) begin
        n_bad++;
        $display("FAIL clear_restart[%0d]: got v=%0b d=%0d w=%0b, want v=1 d=%0d w=%0b",
                 k, ov[k+5], od[k+5], ow[k+5], e, (k == 3));
      end
    end
    n_cmp++;
    if (ov[9] !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_tail: got v=%0b, want v=0", ov[9]);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    do_clear(); clear_stim(); mode = 1'b0;
    for (int k = 0; k < 4; k++) begin sv[k] = 1'b1; sc[k] = 1'b1; sd[k] = 12'sd400; end
    run_seq(7);
    in_valid = 1'b1; in_chan = 1'b1; data_in = 12'sd400;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    #2;
    n_cmp++;
    if (out_valid !== 1'b0 || out_chan !== 1'b0 || out_warm !== 1'b0 || data_out !== 12'sd0) begin
      n_bad++;
      $display("FAIL reset_async: got v=%0b c=%0d w=%0b d=%0d, want all 0",
               out_valid, out_chan, out_warm, data_out);
    end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    run_seq(7);
    for (int t = 0; t < 2; t++) begin
      n_cmp++;
      if (ov[t] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_lost[%0d]: got v=%0b, want v=0", t, ov[t]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      e = 100 * (k + 1);
      n_cmp++;
      if (ov[k+2] !== 1'b1 || oc[k+2] !== 1'b1 || od[k+2] !== e || ow[k+2] !== (k == 3)) begin
        n_bad++;
        $display("FAIL reset_restart[%0d]: got v=%0b c=%0d d=%0d w=%0b, want v=1 c=1 d=%0d w=%0b",
                 k, ov[k+2], oc[k+2], od[k+2], ow[k+2], e, (k == 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_boxcar_step();
    test_exp_step();
    test_boxcar_ramp();
    test_interleave();
    test_negative();
    test_stall();
    test_clear_inflight();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/moving_avg_mc.md
# moving_avg_mc

Multi-channel, time-multiplexed averaging filter for the FM-transmitter sample path. It generalises the single-channel leaky integrator in three ways: parametrised depth, parametrised channel count, and a run-time choice between a true boxcar (moving-sum) filter and the first-order exponential filter. Each channel keeps its own history ring, accumulator, write pointer and fill counter. The block sits between the ADC/audio sample source and the pre-emphasis/modulator stages.

## Interface
- `BITS_X`, 12: signed sample width, in and out.
- `LOG2_STAGES`, 4: depth = 2**LOG2_STAGES; also the output shift. Legal range 1..8.
- `CHANNELS`, 2: number of independent channels, ≥1. CH_W = max(1, ceil_log2(CHANNELS)).
- `clock`  in  1  rising-edge clock, single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  pipeline advance; low = stall.
- `clear`  in  1  synchronous flush of all channel state.
- `mode`  in  1  0 = boxcar, 1 = exponential.
- `in_valid`  in  1  sample present this cycle.
- `in_chan`  in  CH_W  channel index of the sample.
- `data_in`  in  BITS_X  signed sample.
- `out_valid`  out  1  one-cycle strobe per result.
- `out_chan`  out  CH_W  channel of the result.
- `out_warm`  out  1  channel has received ≥ DEPTH samples since reset/clear.
- `data_out`  out  BITS_X  signed filtered sample.

## Operation
- **Accept:** a sample is accepted when `in_valid & enable & ~clear`. There is no backpressure; one sample per cycle is allowed, in any channel order, including the same channel back-to-back.
- **Per channel:**
  - `acc[c]`, signed, BITS_X+LOG2_STAGES bits.
  - `ptr[c]`, LOG2_STAGES bits, wraps DEPTH-1 → 0.
  - `fill[c]`, saturates at DEPTH.
  - `hist[c][DEPTH]`, may be RAM; contents are not reset.
- **Boxcar (mode = 0):**
  - `oldest = (fill[c] == DEPTH) ? hist[c][ptr[c]] : 0`.
  - `acc += sext(x) - sext(oldest)`.
  - `hist[c][ptr[c]] = x`, then `ptr++`.
- **Exponential (mode = 1):**
  - `acc += sext(x) - (acc >>> LOG2_STAGES)`, using the pre-update acc.
  - `hist` and `ptr` are still written and advanced, so later mode switches stay consistent.
- **Output (both modes):** `data_out = new_acc >>> LOG2_STAGES`, arithmetic shift (floor), truncated to BITS_X.
- **Overflow:** none is possible. In both modes |acc| ≤ DEPTH·2^(BITS_X-1); no saturation logic.
- **Warm flag:** `fill[c]` increments on every accept until DEPTH. `out_warm` reports the post-update fill == DEPTH of the output channel.
- **Mode change without `clear`:** legal. The accumulator is kept as is and subsequent updates use the new mode's equation.
- **Same-channel accepts back-to-back:** results must equal the sequential ideal model for any channel sequence. Forwarding of acc, ptr and hist over in-flight pipeline stages is mandatory.
- **`clear`:**
  - Zeroes every acc, ptr and fill.
  - Kills all in-flight samples; no `out_valid` is produced for them.
  - A sample presented in the same cycle is dropped.
  - `data_out` and `out_chan` hold their values.

## Timing
- **Latency:** a sample accepted at edge N produces `out_valid` high for the cycle after edge N+2.
- **Throughput:** 1 sample/clock.
- **`enable` low:**
  - Nothing is accepted; all stages freeze and `out_valid` = 0.
  - `data_out`, `out_chan` and `out_warm` hold.
  - On re-enable, frozen samples complete with their original relative spacing.
- **`clear`** acts whether or not `enable` is high.
- **Reset values** (all, asynchronously): `out_valid` 0, `out_chan` 0, `out_warm` 0, `data_out` 0. Also all acc, ptr, fill and pipeline valids are 0.
- **`reset` mid-stream:** in-flight samples are lost. The first sample after reset release behaves as the first-ever sample.

## Test plan
Benches use BITS_X = 12, LOG2_STAGES = 2, CHANNELS = 2 unless stated.
- **Boxcar step:** mode 0, ch0, data_in = 400 every cycle → data_out 100, 200, 300, 400, 400…; `out_warm` rises with the 4th result; first `out_valid` 3 edges after the first accept.
- **Exponential step:** mode 1, ch0, data_in = 400 repeated → acc 400/700/925/1094, data_out 100, 175, 231, 273…, converging to 400 and never exceeding it.
- **Interleave:**
  - ch0 = 400 and ch1 = -400 alternating every cycle, boxcar → ch0 gives 100, 200, 300, 400; ch1 gives -100, -200, -300, -400; no cross-talk.
  - Repeat with a ch0, ch0, ch1 pattern to exercise forwarding.
- **Negative floor / full-scale:**
  - Boxcar, data_in = -1 constant → data_out -1 from the first result.
  - data_in = -2048 for 4 samples → -512, -1024, -1536, -2048, with no overflow.
- **Clear / enable:**
  - Stall `enable` for 5 cycles mid-stream → no `out_valid` during the stall; results identical to an unstalled run.
  - Assert `clear` with 2 samples in flight → those 2 samples produce no output; the next step restarts at 100; `out_warm` = 0.
- **Reset mid-operation:** pulse `reset` asynchronously between edges → all outputs 0 immediately; behaviour after release matches the boxcar step test.
